// File: rtl/gearbox_pkg.sv
// Sizing helpers and bit-order utility shared by the parametrised gearbox.
// Supports any IN_W/OUT_W ratio up to GB_MAX_W bits.
package gearbox_pkg;

   localparam int unsigned GB_MAX_W = 512;

   function automatic int unsigned gb_buf_w(input int unsigned in_w, input int unsigned out_w);
      return in_w + 2 * out_w;
   endfunction

   function automatic int unsigned gb_fill_w(input int unsigned in_w, input int unsigned out_w);
      return $clog2(gb_buf_w(in_w, out_w) + 1);
   endfunction

   // Result bit i takes v[w-1-i]; bits at and above w come back zero.
   function automatic logic [GB_MAX_W-1:0] bit_reverse(input logic [GB_MAX_W-1:0] v,
                                                       input int unsigned         w);
      logic [GB_MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < GB_MAX_W; i++) begin
         r[i] = v[GB_MAX_W-1-i];
      end
      return r >> (GB_MAX_W - w);
   endfunction

endpackage

// File: rtl/gearbox_param_if.sv
// Stream handshakes of the gearbox: input words from the deserializer, output words to block decode.
// master = surrounding environment, slave = gearbox.
interface gearbox_param_if #(
   parameter int unsigned IN_W  = 128,
   parameter int unsigned OUT_W = 132
) ();

   logic [IN_W-1:0]  din;
   logic             din_valid;
   logic             din_ready;
   logic [OUT_W-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid
   );

endinterface

// File: rtl/gearbox_bitq.sv
// LSB-aligned bit queue with fill counter; head (oldest) bit at index 0.
// Per cycle: pop OUT_W bits, then optional one-bit slip, then merge the pushed word above the remaining fill.
module gearbox_bitq
   import gearbox_pkg::*;
#(
   parameter int unsigned IN_W  = 128,
   parameter int unsigned OUT_W = 132
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                pop_i,
   input  logic                                slip_i,
   input  logic                                push_i,
   input  logic [IN_W-1:0]                     din_i,
   output logic [OUT_W-1:0]                    head_o,
   output logic [gb_fill_w(IN_W, OUT_W)-1:0]   fill_o
);

   localparam int unsigned BUF_W  = gb_buf_w(IN_W, OUT_W);
   localparam int unsigned FILL_W = gb_fill_w(IN_W, OUT_W);

   logic [BUF_W-1:0]  bits_q, bits_d, bits_pop, bits_slip;
   logic [FILL_W-1:0] fill_q, fill_d, fill_pop, fill_slip;

   // Bits above fill stay zero, so the push can OR-merge without masking.
   always_comb begin
      bits_pop = bits_q;
      fill_pop = fill_q;
      if (pop_i) begin
         bits_pop = bits_q >> OUT_W;
         fill_pop = fill_q - FILL_W'(OUT_W);
      end

      bits_slip = bits_pop;
      fill_slip = fill_pop;
      if (slip_i) begin
         bits_slip = bits_pop >> 1;
         fill_slip = fill_pop - FILL_W'(1);
      end

      bits_d = bits_slip;
      fill_d = fill_slip;
      if (push_i) begin
         bits_d = bits_slip | (BUF_W'(din_i) << fill_slip);
         fill_d = fill_slip + FILL_W'(IN_W);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bits_q <= '0;
         fill_q <= '0;
      end else begin
         bits_q <= bits_d;
         fill_q <= fill_d;
      end
   end

   assign head_o = bits_q[OUT_W-1:0];
   assign fill_o = fill_q;

endmodule

// File: rtl/gearbox_param.sv
// IN_W -> OUT_W gearbox with valid/ready on both sides, bit-slip for block-lock alignment,
// fill status and optional output bit reversal.
module gearbox_param
   import gearbox_pkg::*;
#(
   parameter int unsigned IN_W    = 128,
   parameter int unsigned OUT_W   = 132,
   parameter int unsigned BIT_REV = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   gearbox_param_if.slave                    gb,
   input  logic                              slip,
   output logic                              slip_busy,
   output logic [gb_fill_w(IN_W, OUT_W)-1:0] fill
);

   localparam int unsigned BUF_W  = gb_buf_w(IN_W, OUT_W);
   localparam int unsigned FILL_W = gb_fill_w(IN_W, OUT_W);

   logic [FILL_W-1:0] fill_cur;
   logic [OUT_W-1:0]  head;
   logic [OUT_W-1:0]  dout_word;
   logic              din_ready;
   logic              dout_valid;
   logic              push;
   logic              pop;
   logic              slip_apply;
   logic              slip_pend_q, slip_pend_d;

   // Both ready/valid outputs depend on registered fill only, keeping the two sides decoupled.
   always_comb begin
      din_ready   = (fill_cur <= FILL_W'(BUF_W - IN_W));
      dout_valid  = (fill_cur >= FILL_W'(OUT_W));
      push        = gb.din_valid & din_ready;
      pop         = dout_valid & gb.dout_ready;
      slip_apply  = slip_pend_q & ~pop & (fill_cur != '0);
      slip_pend_d = slip_apply ? 1'b0 : (slip_pend_q | slip);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slip_pend_q <= 1'b0;
      end else begin
         slip_pend_q <= slip_pend_d;
      end
   end

   gearbox_bitq #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_bitq (
      .clk    (clk),
      .rst    (rst),
      .pop_i  (pop),
      .slip_i (slip_apply),
      .push_i (push),
      .din_i  (gb.din),
      .head_o (head),
      .fill_o (fill_cur)
   );

   generate
      if (BIT_REV != 0) begin : g_rev
         always_comb dout_word = OUT_W'(bit_reverse(GB_MAX_W'(head), OUT_W));
      end else begin : g_fwd
         always_comb dout_word = head;
      end
   endgenerate

   assign gb.din_ready  = din_ready;
   assign gb.dout_valid = dout_valid;
   assign gb.dout       = dout_word;
   assign slip_busy     = slip_pend_q;
   assign fill          = fill_cur;

endmodule

// File: tb/tb_gearbox_param.sv
// Directed and random checks of gearbox_param against a bit-queue scoreboard model.
module tb_gearbox_param;
   import gearbox_pkg::*;

   localparam int unsigned IW  = 128;
   localparam int unsigned OW  = 132;
   localparam int unsigned REV = 1;
   localparam int unsigned BW  = IW + 2 * OW;
   localparam int unsigned FW  = $clog2(BW + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          slip;
   logic          busy;
   logic [FW-1:0] fill;
   logic          sweep_go;

   int unsigned n_tests, n_fail, n_pops;
   bit          q[$];
   bit          m_pend;

   gearbox_param_if #(.IN_W(IW), .OUT_W(OW)) gb ();

   gearbox_param #(.IN_W(IW), .OUT_W(OW), .BIT_REV(REV)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .gb        (gb),
      .slip      (slip),
      .slip_busy (busy),
      .fill      (fill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] rword();
      logic [127:0] w;
      for (int k = 0; k < 4; k++) w[k*32 +: 32] = $urandom();
      return w;
   endfunction

   // Called just after a falling edge with inputs already driven; advances one clock.
   task automatic tick();
      bit push, pop, apply;
      logic [511:0] h, e;
      push = gb.din_valid && gb.din_ready;
      pop  = gb.dout_valid && gb.dout_ready;
      if (rst) begin
         q.delete();
         m_pend = 1'b0;
      end else begin
         if (pop) begin
            h = '0;
            e = '0;
            if (q.size() >= OW) for (int i = 0; i < OW; i++) h[i] = q.pop_front();
            for (int i = 0; i < OW; i++) e[i] = (REV != 0) ? h[OW-1-i] : h[i];
            chk("dout", gb.dout, e);
            n_pops++;
         end
         apply = m_pend && !pop && (q.size() > 0);
         if (apply) void'(q.pop_front());
         if (push) for (int i = 0; i < IW; i++) q.push_back(gb.din[i]);
         m_pend = !apply && (m_pend || slip);
      end
      @(posedge clk);
      @(negedge clk);
      chk("fill", fill, q.size());
      chk("dout_valid", gb.dout_valid, q.size() >= OW);
      chk("din_ready", gb.din_ready, q.size() <= 2 * OW);
      chk("slip_busy", busy, m_pend);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      gb.din_valid = 1'b0;
      gb.dout_ready = 1'b0;
      slip = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Parameter sweep: random valid/ready, bit-exact scoreboard per configuration.
   localparam int unsigned SW_IN [4] = '{132, 64, 66, 8};
   localparam int unsigned SW_OUT[4] = '{128, 66, 64, 8};
   localparam int unsigned SW_REV[4] = '{0, 1, 1, 0};

   for (genvar g = 0; g < 4; g++) begin : sw
      localparam int unsigned SIW = SW_IN[g];
      localparam int unsigned SOW = SW_OUT[g];
      localparam int unsigned SRV = SW_REV[g];
      localparam int unsigned SBW = SIW + 2 * SOW;
      localparam int unsigned SFW = $clog2(SBW + 1);

      logic [SFW-1:0] sfill;
      logic           sbusy;
      logic           done;

      gearbox_param_if #(.IN_W(SIW), .OUT_W(SOW)) sgb ();

      gearbox_param #(.IN_W(SIW), .OUT_W(SOW), .BIT_REV(SRV)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .gb        (sgb),
         .slip      (1'b0),
         .slip_busy (sbusy),
         .fill      (sfill)
      );

      initial begin
         bit           sq[$];
         logic [511:0] w, h, e;
         int unsigned  outs, cyc;
         bit           push, pop;
         done = 1'b0;
         sgb.din = '0;
         sgb.din_valid = 1'b0;
         sgb.dout_ready = 1'b0;
         wait (sweep_go === 1'b1);
         outs = 0;
         cyc = 0;
         while (outs < 1000 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            chk("sw_fill", sfill, sq.size());
            chk("sw_fill_max", sfill <= SFW'(SBW), 1'b1);
            chk("sw_dout_valid", sgb.dout_valid, sq.size() >= SOW);
            chk("sw_busy", sbusy, 1'b0);
            for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom();
            sgb.din = w[SIW-1:0];
            sgb.din_valid = ($urandom_range(0, 3) != 0);
            sgb.dout_ready = ($urandom_range(0, 2) != 0);
            push = sgb.din_valid && sgb.din_ready;
            pop = sgb.dout_valid && sgb.dout_ready;
            if (pop && sq.size() >= SOW) begin
               h = '0;
               e = '0;
               for (int i = 0; i < SOW; i++) h[i] = sq.pop_front();
               for (int i = 0; i < SOW; i++) e[i] = (SRV != 0) ? h[SOW-1-i] : h[i];
               chk("sw_dout", sgb.dout, e);
               outs++;
            end
            if (push) for (int i = 0; i < SIW; i++) sq.push_back(w[i]);
            @(posedge clk);
         end
         sgb.din_valid = 1'b0;
         sgb.dout_ready = 1'b0;
         chk("sw_words", outs, 1000);
         done = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed still running, expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      logic [IW-1:0]  d0, d1;
      logic [OW-1:0]  h, e, dsave;
      bit             seen;
      n_tests = 0;
      n_fail = 0;
      n_pops = 0;
      m_pend = 1'b0;
      sweep_go = 1'b0;
      rst = 1'b1;
      slip = 1'b0;
      gb.din = '0;
      gb.din_valid = 1'b0;
      gb.dout_ready = 1'b0;
      @(negedge clk);
      do_reset();
      chk("rst_fill", fill, 0);
      chk("rst_dout_valid", gb.dout_valid, 1'b0);
      chk("rst_din_ready", gb.din_ready, 1'b1);
      chk("rst_slip_busy", busy, 1'b0);
      chk("rst_dout", gb.dout, 0);

      // Two pushes, first word available right after the second
      d0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_ABCD;
      d1 = rword();
      gb.din_valid = 1'b1;
      gb.din = d0;
      tick();
      chk("t1_fill128", fill, 128);
      chk("t1_not_valid", gb.dout_valid, 1'b0);
      gb.din = d1;
      tick();
      gb.din_valid = 1'b0;
      chk("t1_fill256", fill, 256);
      chk("t1_valid", gb.dout_valid, 1'b1);
      h = {d1[3:0], d0};
      for (int i = 0; i < OW; i++) e[i] = h[OW-1-i];
      chk("t1_dout", gb.dout, e);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t1_midrst_fill", fill, 0);
      chk("t1_midrst_valid", gb.dout_valid, 1'b0);

      // Continuous stream: 33 words in, 32 words out, no bubbles
      do_reset();
      n_pops = 0;
      seen = 1'b0;
      gb.dout_ready = 1'b1;
      for (int w = 0; w < 33; w++) begin
         gb.din_valid = 1'b1;
         gb.din = rword();
         if (seen) chk("t2_no_bubble", gb.dout_valid, 1'b1);
         if (gb.dout_valid) seen = 1'b1;
         tick();
      end
      gb.din_valid = 1'b0;
      repeat (4) tick();
      chk("t2_words", n_pops, 32);
      chk("t2_fill0", fill, 0);
      chk("t2_sb_empty", q.size(), 0);

      // Backpressure: fill to 384, hold, then release one word
      do_reset();
      gb.din_valid = 1'b1;
      repeat (3) begin
         chk("t3_ready", gb.din_ready, 1'b1);
         gb.din = rword();
         tick();
      end
      chk("t3_fill384", fill, 384);
      chk("t3_full", gb.din_ready, 1'b0);
      dsave = gb.dout;
      repeat (2) begin
         gb.din = rword();
         tick();
         chk("t3_hold_dout", gb.dout, dsave);
         chk("t3_hold_fill", fill, 384);
      end
      gb.dout_ready = 1'b1;
      tick();
      gb.dout_ready = 1'b0;
      gb.din_valid = 1'b0;
      chk("t3_fill252", fill, 252);
      chk("t3_ready_again", gb.din_ready, 1'b1);

      // Slip with fill=256 and no pop
      do_reset();
      gb.din_valid = 1'b1;
      repeat (2) begin
         gb.din = rword();
         tick();
      end
      gb.din_valid = 1'b0;
      slip = 1'b1;
      tick();
      slip = 1'b0;
      chk("t4_busy_set", busy, 1'b1);
      chk("t4_fill256", fill, 256);
      tick();
      chk("t4_fill255", fill, 255);
      chk("t4_busy_clr", busy, 1'b0);
      gb.din_valid = 1'b1;
      gb.din = rword();
      tick();
      gb.din_valid = 1'b0;
      gb.dout_ready = 1'b1;
      repeat (3) tick();
      gb.dout_ready = 1'b0;

      // Slip during continuous pops waits for a non-pop cycle
      do_reset();
      gb.dout_ready = 1'b1;
      gb.din_valid = 1'b1;
      repeat (5) begin
         gb.din = rword();
         tick();
      end
      slip = 1'b1;
      gb.din = rword();
      tick();
      slip = 1'b0;
      repeat (3) begin
         gb.din = rword();
         tick();
         chk("t4b_wait", busy, 1'b1);
      end
      gb.dout_ready = 1'b0;
      gb.din_valid = 1'b0;
      tick();
      chk("t4b_applied", busy, 1'b0);
      gb.dout_ready = 1'b1;
      repeat (3) tick();
      gb.dout_ready = 1'b0;

      // Slip at fill=0 stays pending until data arrives
      do_reset();
      slip = 1'b1;
      tick();
      slip = 1'b0;
      repeat (3) begin
         tick();
         chk("t5_pending", busy, 1'b1);
         chk("t5_fill0", fill, 0);
      end
      gb.din_valid = 1'b1;
      gb.din = rword();
      tick();
      gb.din_valid = 1'b0;
      chk("t5_busy_after_push", busy, 1'b1);
      chk("t5_fill128", fill, 128);
      tick();
      chk("t5_fill127", fill, 127);
      chk("t5_busy_clr", busy, 1'b0);
      gb.din_valid = 1'b1;
      repeat (2) begin
         gb.din = rword();
         tick();
      end
      gb.din_valid = 1'b0;
      gb.dout_ready = 1'b1;
      repeat (3) tick();
      gb.dout_ready = 1'b0;

      sweep_go = 1'b1;
      for (int c = 0; c < 40000; c++) begin
         if (sw[0].done && sw[1].done && sw[2].done && sw[3].done) break;
         @(negedge clk);
      end
      chk("sweep_done", {sw[3].done, sw[2].done, sw[1].done, sw[0].done}, 4'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
